mul_div_unit: RTL and testbench

- Iterative signed multiply/divide unit on the datapath side of the Mini SRC bus.
- Consumes operand A (Y-register output) and operand B (BusMuxOut).
- Produces a 2*WIDTH-bit result for the Z register pair: z_high and z_low, later moved to HI/LO.
- Multiply is radix-2 Booth; divide is restoring division on magnitudes with sign fix-up. One operation is in flight at a time.

---
 rtl/mini_src_pkg.sv | 19 +
 rtl/mul_div_unit_if.sv | 40 ++++
 rtl/mdu_sign_fix.sv | 23 ++
 rtl/mul_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC multiply/divide unit.
//   MDU_WIDTH   : default operand width
//   MDU_OP_*    : operation select encoding carried on the op signal
//   mdu_state_e : FSM state encoding, also exported on the debug state signal
package mini_src_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic MDU_OP_MUL = 1'b0;
  localparam logic MDU_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the Mini SRC datapath and mul_div_unit.
//   start/op/a/b            : request from the datapath (master)
//   busy/done               : status from the unit (slave)
//   z_high/z_low            : result for the Z register pair
//   div_by_zero             : flagged with done when a DIV had b == 0
//   state                   : debug view of the unit's FSM state
//
// Handshake: start is a request that is accepted on a rising clock edge only
// while busy is low (unit IDLE); op/a/b are sampled on that same edge.
// A start seen while busy is high is dropped, not queued. done is a
// one-cycle pulse marking the cycle in which z_high/z_low/div_by_zero first
// carry the new result; the result then holds until the next done.
interface mul_div_unit_if
  import mini_src_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z_high;
  logic [WIDTH-1:0] z_low;
  logic             div_by_zero;
  mdu_state_e       state;

  modport master (
    output start, op, a, b,
    input  busy, done, z_high, z_low, div_by_zero, state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, z_high, z_low, div_by_zero, state
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation of two words.
//   hi_i/neg_hi_i -> hi_o : hi_i negated when neg_hi_i is set
//   lo_i/neg_lo_i -> lo_o : lo_i negated when neg_lo_i is set
// On entry it turns signed a/b into magnitudes; in FIX it applies the
// remainder (sign of a) and quotient (sign a xor sign b) corrections.
// The magnitude of the most-negative value is read as an unsigned word.
module mdu_sign_fix
  import mini_src_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic             neg_hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             neg_lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  assign hi_o = neg_hi_i ? ({WIDTH{1'b0}} - hi_i) : hi_i;
  assign lo_o = neg_lo_i ? ({WIDTH{1'b0}} - lo_i) : lo_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes with sign fix-up) for the Mini SRC Z register pair.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : mul_div_unit_if slave (start/op/a/b in, busy/done/z/flags out)
// Timing for an accepted start in cycle T: RUN T+1..T+WIDTH, FIX T+WIDTH+1,
// DONE (done pulse) T+WIDTH+2. DIV by zero goes straight to DONE at T+1.
module mul_div_unit
  import mini_src_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic          clock,
  input  logic          clear,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_e       state_q;
  logic             op_q, sign_a_q, sign_b_q, qm1_q;
  logic             busy_q, done_q, div_by_zero_q;
  // acc_q: Booth accumulator (MUL) or partial remainder (DIV); the extra
  // bit absorbs the most-negative multiplicand case.
  logic [WIDTH:0]   acc_q, acc_d;
  // q_q: multiplier being shifted out (MUL) or quotient being built (DIV).
  logic [WIDTH-1:0] q_q, q_d;
  // mcand_q: multiplicand A (MUL) or divisor magnitude |b| (DIV).
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] z_high_q, z_low_q;
  logic [CW-1:0]    count_q;
  logic             qm1_d;

  logic [WIDTH-1:0] mag_a, mag_b, fix_rem, fix_quo;
  logic [WIDTH:0]   addend, booth_sum, div_shift, div_sub;
  logic             div_fits;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_entry_mag (
    .hi_i     (bus.a),
    .neg_hi_i (bus.a[WIDTH-1]),
    .lo_i     (bus.b),
    .neg_lo_i (bus.b[WIDTH-1]),
    .hi_o     (mag_a),
    .lo_o     (mag_b)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .hi_i     (acc_q[WIDTH-1:0]),
    .neg_hi_i (sign_a_q),
    .lo_i     (q_q),
    .neg_lo_i (sign_a_q ^ sign_b_q),
    .hi_o     (fix_rem),
    .lo_o     (fix_quo)
  );

  // One RUN iteration of either algorithm.
  always_comb begin
    addend    = {mcand_q[WIDTH-1], mcand_q};
    booth_sum = acc_q;
    if ({q_q[0], qm1_q} == 2'b01) begin
      booth_sum = acc_q + addend;
    end else if ({q_q[0], qm1_q} == 2'b10) begin
      booth_sum = acc_q - addend;
    end
    // Remainder stays below |b|, so the shifted value fits WIDTH+1 bits.
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, mcand_q});
    div_sub   = div_shift - {1'b0, mcand_q};
    if (op_q == MDU_OP_MUL) begin
      acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
    end else begin
      acc_d = div_fits ? div_sub : div_shift;
      q_d   = {q_q[WIDTH-2:0], div_fits};
      qm1_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= MDU_IDLE;
      op_q          <= MDU_OP_MUL;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      qm1_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      acc_q         <= '0;
      q_q           <= '0;
      mcand_q       <= '0;
      z_high_q      <= '0;
      z_low_q       <= '0;
      count_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (bus.start) begin
            op_q          <= bus.op;
            sign_a_q      <= bus.a[WIDTH-1];
            sign_b_q      <= bus.b[WIDTH-1];
            qm1_q         <= 1'b0;
            acc_q         <= '0;
            busy_q        <= 1'b1;
            div_by_zero_q <= 1'b0;
            count_q       <= CW'(WIDTH);
            state_q       <= MDU_RUN;
            if (bus.op == MDU_OP_DIV) begin
              q_q     <= mag_a;
              mcand_q <= mag_b;
              if (bus.b == '0) begin
                z_high_q      <= bus.a;
                z_low_q       <= '1;
                div_by_zero_q <= 1'b1;
                done_q        <= 1'b1;
                state_q       <= MDU_DONE;
              end
            end else begin
              q_q     <= bus.b;
              mcand_q <= bus.a;
            end
          end
        end
        MDU_RUN: begin
          acc_q   <= acc_d;
          q_q     <= q_d;
          qm1_q   <= qm1_d;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= MDU_FIX;
          end
        end
        MDU_FIX: begin
          if (op_q == MDU_OP_MUL) begin
            z_high_q <= acc_q[WIDTH-1:0];
            z_low_q  <= q_q;
          end else begin
            z_high_q <= fix_rem;
            z_low_q  <= fix_quo;
          end
          done_q  <= 1'b1;
          state_q <= MDU_DONE;
        end
        MDU_DONE: begin
          busy_q  <= 1'b0;
          state_q <= MDU_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= MDU_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.z_high      = z_high_q;
  assign bus.z_low       = z_low_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mul_div_unit;
  import mini_src_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clock = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  // Clock / reset block
  always #5 clock = ~clock;

  // Reference model: {div_by_zero, z_high, z_low} from signed arithmetic.
  function automatic logic [2*W:0] model(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv);
    longint      sa, sb, qq, rr;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (o == MDU_OP_MUL) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (bv == '0) return {1'b1, av, {W{1'b1}}};
    qq = sa / sb;
    rr = sa % sb;
    return {1'b0, rr[W-1:0], qq[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: issue one operation, optionally poke a DIV 100/3 start at cycle
  // 'poke' while busy, and check timing and results.
  task automatic do_op(input string tag, input logic o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input int poke);
    logic [2*W:0] exp;
    int           lat;
    int           exp_lat;
    bit           busy_ok;
    bit           dz;
    exp     = model(o, av, bv);
    dz      = (o == MDU_OP_DIV) && (bv == '0);
    exp_lat = dz ? 1 : LAT;
    @(negedge clock);
    chk($sformatf("%s:idle", tag), {60'd0, bus.state, bus.busy, bus.done},
        {60'd0, MDU_IDLE, 1'b0, 1'b0});
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    lat       = 0;
    busy_ok   = 1'b1;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk($sformatf("%s:dbz_at_accept", tag), 64'(bus.div_by_zero), 64'(dz));
        if (!dz) chk($sformatf("%s:z_hold", tag), {bus.z_high, bus.z_low}, {prev_hi, prev_lo});
        bus.start = 1'b0;
        bus.op    = 1'($urandom_range(0, 1));
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      if (k == poke) begin
        bus.start = 1'b1;
        bus.op    = MDU_OP_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
      end else if (k == poke + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) lat = k;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    chk($sformatf("%s:latency", tag), 64'(lat), 64'(exp_lat));
    chk($sformatf("%s:busy", tag), 64'(busy_ok), 64'd1);
    chk($sformatf("%s:z_high", tag), 64'(bus.z_high), 64'(exp[2*W-1:W]));
    chk($sformatf("%s:z_low", tag), 64'(bus.z_low), 64'(exp[W-1:0]));
    chk($sformatf("%s:dbz", tag), 64'(bus.div_by_zero), 64'(exp[2*W]));
    prev_hi = exp[2*W-1:W];
    prev_lo = exp[W-1:0];
  endtask

  initial begin
    logic          ro;
    logic [W-1:0]  ra, rb;
    bit            quiet;

    clear     = 1'b0;
    bus.start = 1'b0;
    bus.op    = MDU_OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    chk("reset_status", {59'd0, bus.state, bus.busy, bus.done, bus.div_by_zero},
        {59'd0, MDU_IDLE, 3'b000});
    chk("reset_z", {bus.z_high, bus.z_low}, 64'd0);
    repeat (2) @(negedge clock);
    clear = 1'b1;

    // Directed cases
    do_op("mul_6x7",      MDU_OP_MUL, 32'd6,        32'd7,        0);
    do_op("mul_m3x5",     MDU_OP_MUL, 32'hFFFFFFFD, 32'd5,        0);
    do_op("mul_min_min",  MDU_OP_MUL, 32'h80000000, 32'h80000000, 0);
    do_op("div_m7_2",     MDU_OP_DIV, 32'hFFFFFFF9, 32'd2,        0);
    do_op("div_min_m1",   MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op("div_9_0",      MDU_OP_DIV, 32'd9,        32'd0,        0);
    do_op("mul_after_dz", MDU_OP_MUL, 32'd6,        32'd7,        10);
    do_op("div_100_3",    MDU_OP_DIV, 32'd100,      32'd3,        0);

    // Mid-operation asynchronous reset
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = MDU_OP_MUL;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (14) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    chk("midrst_status", {59'd0, bus.state, bus.busy, bus.done, bus.div_by_zero},
        {59'd0, MDU_IDLE, 3'b000});
    chk("midrst_z", {bus.z_high, bus.z_low}, 64'd0);
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (bus.done || bus.busy) quiet = 1'b0;
    end
    clear = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (bus.done || bus.busy) quiet = 1'b0;
    end
    chk("midrst_quiet", 64'(quiet), 64'd1);
    prev_hi = '0;
    prev_lo = '0;
    do_op("after_reset", MDU_OP_DIV, 32'hFFFFFF9C, 32'd7, 0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h80000000;
        4: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op($sformatf("rand%0d", i), ro, ra, rb, (i % 3 == 0) ? 5 + i : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
